// File: rtl/keylock_pkg.sv
// Shared keylock link definitions: symbol width, receiver state type, default frame shape.
// Used by both the multi-digit sender and the multireceive receiver.
package keylock_pkg;
  localparam int SYM_W      = 3;
  localparam int DEF_DIGITS = 6;
  localparam int DEF_SETTLE = 1000;

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    QUAL_HIGH = 2'd1,
    WAIT_LOW  = 2'd2,
    QUAL_LOW  = 2'd3
  } rx_state_t;
endpackage

// File: rtl/level_qualifier.sv
// Two-flop synchroniser plus settle qualification of one asynchronous level; o_rise/o_fall fire on
// the cycle the level has been seen stable for SETTLE samples (2+SETTLE after the pin edge); no backpressure.
module level_qualifier
  import keylock_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_lvl,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  logic            r_s1, r_s2;
  rx_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;

  assign o_sync = r_s2;
  // Events are combinational so the caller samples its data on the same edge the level qualifies.
  assign o_rise = !i_clear && (r_state == QUAL_HIGH) &&  r_s2 && (r_cnt >= CNT_LAST);
  assign o_fall = !i_clear && (r_state == QUAL_LOW)  && !r_s2 && (r_cnt >= CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= WAIT_HIGH;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_lvl;
      r_s2 <= r_s1;
      if (i_clear) begin
        r_state <= WAIT_HIGH;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          WAIT_HIGH: if (r_s2) begin
            r_state <= QUAL_HIGH;
            r_cnt   <= CNT_W'(1);
          end
          QUAL_HIGH: if (!r_s2) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt >= CNT_LAST) begin
            r_state <= WAIT_LOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          WAIT_LOW: if (!r_s2) begin
            r_state <= QUAL_LOW;
            r_cnt   <= CNT_W'(1);
          end
          QUAL_LOW: if (r_s2) begin
            r_state <= WAIT_LOW;
            r_cnt   <= '0;
          end else if (r_cnt >= CNT_LAST) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          default: begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/multireceive.sv
// Receives the 3-bit parallel symbol link and packs DIGITS symbols into data; valid pulses the cycle
// after the final capture; no backpressure. MULTIRECEIVE_TIMEOUT_EN enables the stalled-frame abort (err).
module multireceive
  import keylock_pkg::*;
#(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = 2400000
) (
  input  logic                    hwclk,
  input  logic                    reset,
  input  logic                    enabled,
  input  logic                    in0,
  input  logic                    in1,
  input  logic                    in2,
  input  logic                    controlIn,
  output logic [SYM_W*DIGITS-1:0] data,
  output logic                    valid,
  output logic                    busy,
  output logic                    err
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [SYM_W-1:0]        r_d1, r_d2;
  logic [IDX_W-1:0]        r_idx;
  logic [SYM_W*DIGITS-1:0] r_shadow, r_data, w_frame;
  logic                    r_valid;
  logic                    w_sync, w_take, w_fall, w_abort, w_clear, w_unused;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_d1 <= '0;
      r_d2 <= '0;
    end else begin
      r_d1 <= {in2, in1, in0};
      r_d2 <= r_d1;
    end
  end

  assign w_clear = !enabled || w_abort;

  level_qualifier #(.SETTLE(SETTLE)) u_strobe (
    .i_clk   (hwclk),
    .i_reset (reset),
    .i_clear (w_clear),
    .i_lvl   (controlIn),
    .o_sync  (w_sync),
    .o_rise  (w_take),
    .o_fall  (w_fall)
  );

  // Shadow with the symbol being taken merged in, so the last symbol goes straight to data.
  always_comb begin
    w_frame = r_shadow;
    w_frame[r_idx*SYM_W +: SYM_W] = r_d2;
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_idx    <= '0;
      r_shadow <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_clear) begin
        r_idx    <= '0;
        r_shadow <= '0;
      end else if (w_take) begin
        if (r_idx == IDX_LAST) begin
          r_idx    <= '0;
          r_shadow <= '0;
          r_data   <= w_frame;
          r_valid  <= 1'b1;
        end else begin
          r_idx    <= r_idx + 1'b1;
          r_shadow <= w_frame;
        end
      end
    end
  end

`ifdef MULTIRECEIVE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_to;
  logic            r_err;

  assign w_abort = enabled && busy && !w_sync && (r_to == TO_LAST);

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_to  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (!enabled || !busy || w_sync || w_abort) r_to <= '0;
      else                                        r_to <= r_to + 1'b1;
    end
  end

  assign err      = r_err;
  assign w_unused = w_fall;
`else
  assign w_abort  = 1'b0;
  assign err      = 1'b0;
  assign w_unused = ^{w_fall, w_sync, (TIMEOUT > 0)};
`endif

  assign data  = r_data;
  assign valid = r_valid;
  assign busy  = (r_idx != '0);
endmodule

// File: tb/tb_multireceive.sv
// Directed bench for multireceive with SETTLE=4, DIGITS=6, TIMEOUT=64.
module tb_multireceive;
  logic        hwclk = 1'b0;
  logic        reset, enabled, in0, in1, in2, controlIn;
  logic [17:0] data;
  logic        valid, busy, err;

  int ncmp = 0;
  int nmis = 0;
  int vcnt = 0;
  int ecnt = 0;
  int v0, e0;

  multireceive #(.DIGITS(6), .SETTLE(4), .TIMEOUT(64)) dut (
    .hwclk     (hwclk),
    .reset     (reset),
    .enabled   (enabled),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .controlIn (controlIn),
    .data      (data),
    .valid     (valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 hwclk = ~hwclk;

  // Pulse counters sampled on the falling edge; a stretched pulse counts twice.
  always @(negedge hwclk) begin
    if (valid) vcnt++;
    if (err)   ecnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send_sym(input logic [2:0] s, input int hi, input int lo);
    {in2, in1, in0} = s;
    controlIn = 1'b1;
    tick(hi);
    controlIn = 1'b0;
    tick(lo);
  endtask

  task automatic send_frame(input logic [17:0] f);
    for (int k = 0; k < 6; k++) send_sym(f[3*k +: 3], 10, 10);
  endtask

  initial begin
    reset = 1'b1; enabled = 1'b0; controlIn = 1'b0;
    {in2, in1, in0} = 3'd0;
    tick(3);
    chk("reset_data",  32'(data),  32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_busy",  32'(busy),  32'h0);
    chk("reset_err",   32'(err),   32'h0);
    reset = 1'b0; enabled = 1'b1;
    tick(2);

    // Clean frame 1..6
    v0 = vcnt;
    send_sym(3'd1, 10, 10);
    chk("clean_busy_mid", 32'(busy), 32'h1);
    for (int k = 2; k <= 6; k++) send_sym(3'(k), 10, 10);
    chk("clean_valid_cnt", 32'(vcnt - v0), 32'h1);
    chk("clean_data",      32'(data),      32'(18'o654321));
    chk("clean_busy_end",  32'(busy),      32'h0);

    // Two-cycle strobe glitch carrying 7 must be ignored
    {in2, in1, in0} = 3'd7;
    controlIn = 1'b1;
    tick(2);
    controlIn = 1'b0;
    tick(10);
    chk("glitch_busy", 32'(busy), 32'h0);
    v0 = vcnt;
    send_frame(18'o654321);
    chk("glitch_valid_cnt", 32'(vcnt - v0), 32'h1);
    chk("glitch_data",      32'(data),      32'(18'o654321));

    // Partial frame discarded by enabled low
    v0 = vcnt;
    send_sym(3'd1, 10, 10);
    send_sym(3'd1, 10, 10);
    send_sym(3'd1, 10, 10);
    chk("partial_busy", 32'(busy), 32'h1);
    enabled = 1'b0;
    tick(2);
    chk("disable_busy", 32'(busy), 32'h0);
    chk("disable_data", 32'(data), 32'(18'o654321));
    enabled = 1'b1;
    tick(2);
    send_frame(18'o777777);
    chk("sevens_valid_cnt", 32'(vcnt - v0), 32'h1);
    chk("sevens_data",      32'(data),      32'(18'o777777));

    // Reset mid-frame after 4 symbols
    for (int k = 0; k < 4; k++) send_sym(3'd2, 10, 10);
    reset = 1'b1;
    tick(1);
    chk("midrst_data",  32'(data),  32'h0);
    chk("midrst_busy",  32'(busy),  32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    reset = 1'b0;
    tick(2);
    v0 = vcnt;
    send_frame(18'o251413);
    chk("postrst_valid_cnt", 32'(vcnt - v0), 32'h1);
    chk("postrst_data",      32'(data),      32'(18'o251413));

    // Strobe held high 100 cycles: one capture only
    v0 = vcnt;
    send_sym(3'd5, 100, 10);
    chk("hold_busy",      32'(busy),      32'h1);
    chk("hold_valid_cnt", 32'(vcnt - v0), 32'h0);
    for (int k = 1; k <= 5; k++) send_sym(3'(k), 10, 10);
    chk("hold_frame_cnt", 32'(vcnt - v0), 32'h1);
    chk("hold_frame",     32'(data),      32'(18'o543215));

    // Stalled frame: two symbols then a long low
    v0 = vcnt; e0 = ecnt;
    send_sym(3'd6, 10, 10);
    send_sym(3'd6, 10, 10);
    tick(70);
`ifdef MULTIRECEIVE_TIMEOUT_EN
    chk("to_err_cnt", 32'(ecnt - e0), 32'h1);
    chk("to_busy",    32'(busy),      32'h0);
    send_frame(18'o654321);
    chk("to_next_cnt",  32'(vcnt - v0), 32'h1);
    chk("to_next_data", 32'(data),      32'(18'o654321));
`else
    chk("stall_err_cnt", 32'(ecnt - e0), 32'h0);
    chk("stall_busy",    32'(busy),      32'h1);
    for (int k = 1; k <= 4; k++) send_sym(3'(k), 10, 10);
    chk("stall_done_cnt", 32'(vcnt - v0), 32'h1);
    chk("stall_data",     32'(data),      32'(18'o432166));
    chk("err_never",      32'(ecnt),      32'h0);
`endif
    chk("end_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule

// File: doc/multireceive.md
# multireceive

Receiving end of the 3-bit parallel symbol link driven by the multi-digit sender. Samples `in0..in2` plus the `controlIn` strobe from another board, synchronises and qualifies them, and assembles `DIGITS` consecutive 3-bit symbols into one packed word. It reports completion with a one-cycle `valid` pulse. It sits at the input pins of the keylock board, feeding the code comparator.

## Interface
- `DIGITS`, 6: symbols per frame.
- `SETTLE`, 1000: cycles a synchronised `controlIn` level must hold before it is accepted (high or low).
- `TIMEOUT`, 2400000: maximum cycles `controlIn` may stay low mid-frame (only used with timeout feature).

- `hwclk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `enabled`  in  1  receiver armed; low forces IDLE, discards partial frame.
- `in0`, `in1`, `in2`  in  1 each  symbol bits, asynchronous; `in0` is LSB.
- `controlIn`  in  1  symbol strobe, asynchronous; high = symbol present.
- `data`  out  3*DIGITS  packed frame; symbol k occupies bits [3k+2:3k]; symbol 0 is first received.
- `valid`  out  1  one-cycle pulse, frame complete, `data` updated.
- `busy`  out  1  high while a frame is partially received.
- `err`  out  1  one-cycle pulse on frame abort (timeout only).

## Operation
- All four inputs pass through a 2-flop synchroniser; all logic uses synchronised copies.
- States:
  - WAIT_HIGH: waiting for strobe.
  - QUAL_HIGH: counting a stable high.
  - WAIT_LOW: symbol taken, waiting for strobe release.
  - QUAL_LOW: counting a stable low.
- Symbol counter `idx` ranges 0..DIGITS-1. Settle counter is `$clog2(SETTLE+1)` bits. Timeout counter is `$clog2(TIMEOUT+1)` bits.
- WAIT_HIGH: strobe high -> QUAL_HIGH, settle counter = 1.
- QUAL_HIGH:
  - Strobe low -> WAIT_HIGH; the glitch is ignored and `idx` is unchanged.
  - Counter reaches SETTLE -> capture the synchronised 3-bit symbol into shadow slot `idx` -> WAIT_LOW.
  - If `idx` == DIGITS-1: copy the shadow to `data` next cycle, pulse `valid`, reset `idx` to 0.
  - Otherwise: increment `idx`.
- WAIT_LOW: strobe low -> QUAL_LOW, counter = 1.
- QUAL_LOW:
  - Strobe high before SETTLE -> WAIT_LOW.
  - Counter reaches SETTLE -> WAIT_HIGH.
- `busy` = (`idx` != 0).
- `enabled` low: next cycle state = WAIT_HIGH, `idx` = 0, counters cleared. `data` is retained.
- `enabled` rising while strobe is already high:
  - Qualification starts from WAIT_HIGH, so the symbol is accepted.
  - This is intended: a sender enabled simultaneously may already be driving its first symbol.

## Timing
- Reset values: `data`=0, `valid`=0, `busy`=0, `err`=0; state WAIT_HIGH, `idx`=0, all counters 0. Reset has priority over `enabled`.
- Capture latency: symbol sampled 2 (sync) + SETTLE cycles after the pin-level strobe rise.
- `valid` asserts the cycle after the final capture, for exactly one cycle.
- `data` changes only on that cycle and holds until the next completed frame.
- Back-to-back frames: need no gap beyond the normal SETTLE low qualification.
- Data pins must be stable from strobe rise through SETTLE cycles; only the final sample is used.
- Strobe held high indefinitely: exactly one symbol is captured.

## Configuration
- `MULTIRECEIVE_TIMEOUT_EN` defined:
  - In WAIT_LOW, QUAL_LOW, WAIT_HIGH or QUAL_HIGH with `busy` high, the timeout counter counts cycles of synchronised strobe low.
  - It clears when the strobe is high.
  - When it reaches TIMEOUT: pulse `err` for one cycle, clear `idx` and shadow, go to WAIT_HIGH. `data` is untouched.
- Macro undefined: no timeout counter; `err` tied 0; a partial frame waits forever.

## Structure
- Shared package `keylock_pkg`:
  - Symbol width constant `SYM_W` = 3.
  - State enum type `rx_state_t`.
  - Default `DIGITS`/`SETTLE` constants, shared with the sender.
- One sub-module: `level_qualifier`. It contains the synchroniser and settle counter and outputs qualified rise/fall events. It is reused for the strobe only.

## Test plan
Bench parameters: SETTLE=4, DIGITS=6, TIMEOUT=64 unless stated.
- Clean frame, symbols 1,2,3,4,5,6, each with strobe high 10 / low 10 cycles -> one `valid` pulse; `data`=18'o654321; `busy` low afterwards.
- Strobe glitch high for 2 cycles before symbol 1 -> ignored; `data` identical to clean frame.
- `enabled` dropped after 3 symbols, then a full frame 7,7,7,7,7,7 -> no `valid` for partial frame; then `data`=18'o777777.
- `reset` asserted mid-frame after 4 symbols -> all outputs 0 next cycle; next full frame decoded correctly.
- With `MULTIRECEIVE_TIMEOUT_EN`: 2 symbols, then strobe low 70 cycles -> `err` pulse ~64 cycles after low qualifies; `idx` reset. Without the macro: no `err`, and 4 further symbols complete the frame.
- Strobe held high 100 cycles with data 5 -> exactly one capture; `idx`=1.
